// File: rtl/cavlc_level_decoder_if.sv
// Handshake bundles for cavlc_level_decoder: level-pair input and level output.
interface cavlc_lvl_in_if #(
  parameter int PREFIX_W = 5
);
  logic                InValid;
  logic                InReady;
  logic [PREFIX_W-1:0] LevelPrefix;
  logic [15:0]         LevelSuffix;
  logic [3:0]          SuffixSize;

  modport master (
    output InValid, LevelPrefix, LevelSuffix,
    input  InReady, SuffixSize
  );
  modport slave (
    input  InValid, LevelPrefix, LevelSuffix,
    output InReady, SuffixSize
  );
endinterface

interface cavlc_lvl_out_if #(
  parameter int LEVEL_W = 16
);
  logic                      OutValid;
  logic                      OutReady;
  logic signed [LEVEL_W-1:0] LevelOut;
  logic                      OutLast;

  modport master (
    output OutValid, LevelOut, OutLast,
    input  OutReady
  );
  modport slave (
    input  OutValid, LevelOut, OutLast,
    output OutReady
  );
endinterface

// File: rtl/cavlc_level_decoder.sv
// CAVLC level-run decoder: trailing ones, then coded levels with suffixLength.
// Define CAVLC_LEVEL_ESCAPE_EN to decode extended prefixes (>=16).
module cavlc_level_decoder #(
  parameter  int LEVEL_W   = 16,
  parameter  int MAX_COEFF = 16,
  parameter  int PREFIX_W  = 5,
  localparam int CW = $clog2(MAX_COEFF + 1)
) (
  input  logic            Clk,
  input  logic            nReset,
  input  logic            Start,
  input  logic [CW-1:0]   TotalCoeff,
  input  logic [1:0]      TrailingOnes,
  input  logic [2:0]      T1Signs,
  cavlc_lvl_in_if.slave   li,
  cavlc_lvl_out_if.master lo,
  output logic            Busy,
  output logic            Done,
  output logic            Error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] T1    = 2'd1;
  localparam logic [1:0] LEVEL = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  localparam int LCW = LEVEL_W + 2;

  localparam logic [PREFIX_W-1:0] P14 = PREFIX_W'(14);
  localparam logic [PREFIX_W-1:0] P15 = PREFIX_W'(15);

  localparam logic [LCW:0] PMAX =
    {{(LCW + 1 - (LEVEL_W - 1)){1'b0}}, {(LEVEL_W - 1){1'b1}}};
  localparam logic [LCW:0] NMAX = PMAX + (LCW + 1)'(1);

  logic [1:0]                state;
  logic [2:0]                sl;
  logic [CW-1:0]             tc;
  logic [CW-1:0]             cnt;
  logic [1:0]                t1n;
  logic [2:0]                t1s;
  logic                      first;
  logic                      ov;
  logic signed [LEVEL_W-1:0] lvl;
  logic                      last;
  logic                      done_q;
  logic                      err_q;

  logic [PREFIX_W-1:0]       prefix;
  logic [3:0]                ssz;
  logic [15:0]               sfx;
  logic [PREFIX_W-1:0]       pmin;
  logic [LCW-1:0]            lc;
  logic [LCW:0]              mag;
  logic [LCW:0]              thr;
  logic                      neg;
  logic                      sat;
  logic signed [LEVEL_W-1:0] lvl_n;
  logic [2:0]                sl_a;
  logic [2:0]                sl_n;
  logic                      esc_bad;
  logic                      xfer;
  logic                      drain;
  logic [CW-1:0]             cnt_n;

`ifdef CAVLC_LEVEL_ESCAPE_EN
  localparam logic [PREFIX_W-1:0] P3  = PREFIX_W'(3);
  localparam logic [PREFIX_W-1:0] P16 = PREFIX_W'(16);
  logic [PREFIX_W-1:0] pm3;
  assign pm3     = prefix - P3;
  assign esc_bad = 1'b0;
`else
  assign esc_bad = prefix > P15;
`endif

  assign prefix = li.LevelPrefix;
  assign cnt_n  = cnt + CW'(1);
  assign drain  = ov & lo.OutReady;
  assign xfer   = li.InValid & li.InReady;

  assign li.InReady    = (state == LEVEL) & (~ov | lo.OutReady);
  assign li.SuffixSize = ssz;
  assign lo.OutValid   = ov;
  assign lo.LevelOut   = lvl;
  assign lo.OutLast    = last;

  assign Busy  = state != IDLE;
  assign Done  = done_q | ((state == FLUSH) & drain);
  assign Error = err_q;

  always_comb begin
    unique case (1'b1)
      (prefix == P14) && (sl == 3'd0): ssz = 4'd4;
`ifdef CAVLC_LEVEL_ESCAPE_EN
      (prefix >= P15):                 ssz = pm3[3:0];
`else
      (prefix == P15):                 ssz = 4'd12;
      (prefix > P15):                  ssz = 4'd0;
`endif
      default:                         ssz = {1'b0, sl};
    endcase
  end

  always_comb begin
    sfx  = li.LevelSuffix & ((16'd1 << ssz) - 16'd1);
    pmin = (prefix > P15) ? P15 : prefix;
    lc   = (LCW'(pmin) << sl) + LCW'(sfx);
    if ((prefix >= P15) && (sl == 3'd0))
      lc = lc + LCW'(15);
`ifdef CAVLC_LEVEL_ESCAPE_EN
    if (prefix >= P16)
      lc = lc + (LCW'(1) << pm3) - LCW'(4096);
`endif
    if (first && (t1n != 2'd3))
      lc = lc + LCW'(2);
    // even codes map to +, odd to -; add 2 or 1 before halving
    mag   = ({1'b0, lc} + {{(LCW - 1){1'b0}}, ~lc[0], lc[0]}) >> 1;
    neg   = lc[0];
    sat   = neg ? (mag > NMAX) : (mag > PMAX);
    if (sat)
      lvl_n = neg ? {1'b1, {(LEVEL_W - 1){1'b0}}}
                  : {1'b0, {(LEVEL_W - 1){1'b1}}};
    else
      lvl_n = neg ? -LEVEL_W'(mag) : LEVEL_W'(mag);
    sl_a = (sl == 3'd0) ? 3'd1 : sl;
    thr  = (LCW + 1)'(3) << (sl_a - 3'd1);
    sl_n = ((mag > thr) && (sl_a < 3'd6)) ? sl_a + 3'd1 : sl_a;
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state  <= IDLE;
      sl     <= '0;
      tc     <= '0;
      cnt    <= '0;
      t1n    <= '0;
      t1s    <= '0;
      first  <= 1'b0;
      ov     <= 1'b0;
      lvl    <= '0;
      last   <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (drain) begin
        ov   <= 1'b0;
        last <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (Start) begin
            tc    <= TotalCoeff;
            t1n   <= TrailingOnes;
            t1s   <= T1Signs;
            first <= 1'b1;
            cnt   <= '0;
            sl    <= ((32'(TotalCoeff) > 32'd10) &&
                      (TrailingOnes != 2'd3)) ? 3'd1 : 3'd0;
            if (TotalCoeff == '0)
              done_q <= 1'b1;
            else if (TrailingOnes != 2'd0)
              state <= T1;
            else
              state <= LEVEL;
          end
        end
        T1: begin
          if (~ov | lo.OutReady) begin
            ov   <= 1'b1;
            lvl  <= t1s[0] ? '1 : LEVEL_W'(1);
            t1s  <= t1s >> 1;
            cnt  <= cnt_n;
            last <= cnt_n == tc;
            if (cnt_n == CW'(t1n))
              state <= (cnt_n == tc) ? FLUSH : LEVEL;
          end
        end
        LEVEL: begin
          if (xfer) begin
            if (esc_bad) begin
              err_q <= 1'b1;
              state <= IDLE;
              sl    <= '0;
              cnt   <= '0;
            end else begin
              ov    <= 1'b1;
              lvl   <= lvl_n;
              last  <= cnt_n == tc;
              cnt   <= cnt_n;
              sl    <= sl_n;
              first <= 1'b0;
              err_q <= sat;
              if (cnt_n == tc)
                state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (drain) begin
            state <= IDLE;
            sl    <= '0;
            cnt   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/cavlc_level_decoder.md
Name: cavlc_level_decoder

Overview:
Parametrised successor to the single-level processing unit. It decodes a complete CAVLC level run for one block, where the run length comes from TotalCoeff. The block emits the trailing-one levels first, then decodes each coded level from its (level_prefix, level_suffix) pair. It tracks suffixLength internally and tells the bitstream parser how many suffix bits to read. It sits between the coeff-token decoder/bit parser and the run-before/coefficient store, with valid/ready handshakes on both sides.

Parameters:
LEVEL_W, 16, width of signed LevelOut; intermediate levelCode is LEVEL_W+2 bits.
MAX_COEFF, 16, maximum TotalCoeff (16 luma, 15 AC, 4/8 chroma DC); sets TotalCoeff width CW=$clog2(MAX_COEFF+1).
PREFIX_W, 5, width of LevelPrefix input.

Ports:
Clk  in  1  clock.
nReset  in  1  asynchronous active-low reset.
Start  in  1  begin a block; sampled only in IDLE.
TotalCoeff  in  CW  coefficient count, latched on Start.
TrailingOnes  in  2  trailing-one count (0-3), latched on Start.
T1Signs  in  3  trailing-one signs, bit0 first emitted, 1 = negative; latched on Start.
InValid  in  1  LevelPrefix/LevelSuffix valid.
InReady  out  1  decoder accepts a level pair.
LevelPrefix  in  PREFIX_W  level_prefix value.
LevelSuffix  in  16  level_suffix, right-aligned, SuffixSize bits meaningful.
SuffixSize  out  4  combinational levelSuffixSize from LevelPrefix and current suffixLength.
OutValid  out  1  LevelOut valid.
OutReady  in  1  downstream accepts.
LevelOut  out  LEVEL_W  signed level.
OutLast  out  1  qualifies the final level of the block.
Busy  out  1  state != IDLE.
Done  out  1  one-cycle pulse at block completion.
Error  out  1  one-cycle pulse on illegal prefix or saturation.

Behaviour:
- Reset values: all outputs 0; state IDLE; suffixLength 0; counters 0.
- States are IDLE, T1, LEVEL, FLUSH.
- IDLE: on Start, latch inputs. TotalCoeff==0 -> Done pulses next cycle, no output, stay IDLE. TrailingOnes>0 -> T1. Otherwise -> LEVEL.
- Initial suffixLength = 1 if TotalCoeff>10 and TrailingOnes<3, else 0.
- T1: emits one ±1 per cycle from T1Signs, advancing whenever the output register is free or being drained. After TrailingOnes outputs -> LEVEL, or -> FLUSH if TotalCoeff==TrailingOnes.
- LEVEL: InReady = (state==LEVEL) & (!OutValid | OutReady). A transfer is InValid&InReady. Result registered; OutValid rises the cycle after the transfer (latency 1).
- SuffixSize = 4 if prefix==14 and sL==0; prefix-3 if prefix>=15; else sL.
- levelCode = (min(prefix,15)<<sL) + suffix (suffix only if SuffixSize>0).
  - +15 if prefix>=15 and sL==0.
  - +(1<<(prefix-3))-4096 if prefix>=16.
  - +2 if this is the first coded level and TrailingOnes<3.
- Level = even ? (levelCode+2)>>1 : -((levelCode+1)>>1).
- suffixLength update after each coded level:
  - If sL==0, set sL=1.
  - Then, if |level| > (3<<(sL-1)) and sL<6, increment sL.
- Result outside the signed LEVEL_W range: saturate and pulse Error; the sequence continues.
- OutLast is set on the TotalCoeff-th output. When that output handshakes -> IDLE, Done pulses that cycle, and sL/counters are cleared.
- FLUSH: holds the last output until OutReady, then -> IDLE with Done.
- An output that is held (OutValid & !OutReady) keeps LevelOut and OutLast stable.
- Start outside IDLE is ignored.
- nReset mid-block aborts immediately to reset values; no Done is issued.

Optional Feature:
Macro CAVLC_LEVEL_ESCAPE_EN.
- Defined: prefix>=16 is decoded per the escape formula above (High-profile extended prefixes).
- Undefined: a transfer with prefix>15 pulses Error the following cycle, produces no output, drops Busy and returns to IDLE without Done. SuffixSize for prefix>15 reads 0.

Test Plan:
- TC=5, T1=3, T1Signs=3'b010, then pairs (prefix1) and (prefix0, suffix1) with OutReady=1 -> outputs +1,-1,+1,-1,-1; OutLast on the 5th output; Done on the same cycle.
- TC=3, T1=1, T1Signs=1, then pairs (p0) and (p3, suffix0) -> outputs -1,+2,+4. SuffixSize reads 0 for the first pair, then 1; internal sL ends at 2.
- TC=4, T1=3, first pair p14 with SuffixSize==4 and suffix 5 -> level -10.
- Backpressure: during a level run, OutReady held 0 for 3 cycles -> OutValid stays 1, LevelOut stable, InReady 0; resumes with no loss or duplication.
- TC=0 Start -> Done pulse next cycle, OutValid never rises. Separately, nReset asserted after 2 of 5 outputs -> immediate IDLE, all outputs 0, no Done.
- sL=0, T1=3, pair p16 with suffix 0:
  - With CAVLC_LEVEL_ESCAPE_EN defined -> SuffixSize 13, level +2064.
  - Without it -> Error pulse, return to IDLE, no output.
